hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised forwarding/hazard unit for the Minisys-1A pipeline, the successor to the fixed two-source forwarding logic. It keeps a registered scoreboard of in-flight destination writes (GPR, HI, LO) for every stage after ID and produces forwarding selects for any number of ID-stage read ports. It also raises load-use and HI/LO-busy stalls, the latter from a multi-cycle divider countdown. It sits beside the ID stage; its selects are registered into ID/EX by the datapath.

## Interface
- NUM_RD, default 4: number of ID-stage read ports.
- STAGES, default 3: tracked stages after ID; index 0 = EX, 1 = MEM, 2 = WB.
- LOAD_READY, default 2: first stage index at which load data can be forwarded.
- DIV_LAT, default 32: divider latency in cycles.
- SEL_W, default 2: select width; must satisfy 2^SEL_W ≥ STAGES+1.

Ports:
- clock  in  1  pipeline clock; single clock domain.
- reset  in  1  synchronous, active-high.
- pipe_hold  in  1  global freeze (memory wait); scoreboard and counter hold.
- flush  in  1  kill the instruction in ID; no entry is created this cycle.
- issue_valid  in  1  a valid instruction is present in ID.
- issue_regwrite  in  1  the instruction writes a GPR.
- issue_waddr  in  5  GPR destination.
- issue_memread  in  1  the instruction is a load.
- issue_wlo, issue_whi  in  1 each  the instruction writes LO / HI via the pipeline (mtlo, mthi, mult).
- issue_div  in  1  the instruction starts the multi-cycle divider.
- rd_en  in  NUM_RD  per-port read enable.
- rd_kind  in  2*NUM_RD  per port: 00 = GPR, 01 = LO, 10 = HI; 11 is reserved and treated as no read.
- rd_addr  in  5*NUM_RD  per-port GPR address.
- fwd_sel  out  SEL_W*NUM_RD  per port: 0 = register file; k = result of stage k-1.
- stall_req  out  1  ID must hold; a bubble is inserted into EX.
- issue_accept  out  1  equals issue_valid & !stall_req & !flush & !pipe_hold.
- hilo_busy  out  1  divider countdown is nonzero.

## Operation
- Each scoreboard entry holds {v, waddr, load, wlo, whi}. Entries are registered, STAGES deep.
- On a clock edge with pipe_hold=0:
  - entry[i] ← entry[i-1] for i ≥ 1.
  - entry[0] ← issued fields if issue_accept, otherwise all-zero (bubble).
  - The entry leaving index STAGES-1 is dropped.
- On a clock edge with pipe_hold=1, all state holds. flush and issue are ignored.
- GPR match at index i: v & issue-time regwrite & waddr == rd_addr & rd_addr != 0. Writes to $0 are stored with v=0.
- LO/HI match at index i: v & wlo (or whi) for rd_kind 01 (or 10).
- Forwarding select: choose the lowest matching index i (youngest wins) and output fwd_sel = i+1. If nothing matches, output 0.
- Load-use: if the youngest match is a load entry with i < LOAD_READY, assert stall_req. An older non-load match never overrides this.
- Divider countdown:
  - Loads DIV_LAT on issue_accept & issue_div.
  - Otherwise decrements by 1 while nonzero and pipe_hold=0.
  - hilo_busy = (count != 0).
- HI/LO stall: stall_req is also asserted when hilo_busy and the ID instruction reads LO/HI, writes LO/HI, or has issue_div set.
- Ports with rd_en=0 never stall and output fwd_sel=0.
- The flush-qualified term is (issue_valid & !flush). stall_req is gated by it, so a flushed or invalid instruction never stalls.

## Timing
- fwd_sel, stall_req and issue_accept are combinational from registered state plus the current ID inputs. There is zero latency within the cycle.
- An instruction issued at edge t appears at index i after edge t+i+1 (no holds) and is visible to the ID instruction of that cycle.
- Load-use with LOAD_READY=2:
  - A dependent instruction immediately after a load stalls 2 cycles, then forwards with sel=3.
  - With one independent instruction between them, it stalls 1 cycle.
- Divider: a LO/HI reader issued right after div stalls exactly DIV_LAT cycles, then reads with sel=0.
- Simultaneous flush and stall: flush wins. No stall is raised, and a bubble is inserted.
- pipe_hold together with a pending stall: the count is frozen, so the total stall length extends by the number of hold cycles.
- Reset: all entries zeroed and count = 0 on the edge.
  - While reset=1, stall_req=0, issue_accept=0, hilo_busy=0, and all fwd_sel=0 (forced).
  - Reset asserted mid-divide clears the count immediately.

## Test plan
- ALU chain: addu $3 at t, then addu reading $3 on port 0 at t+1, t+2, t+3 → fwd_sel[0] = 1, 2, 3 respectively; register-file read with sel=0 at t+4; stall_req never raised.
- Load-use: lw $5 then addu $6,$5,$5 → stall_req=1 for 2 cycles, then fwd_sel[0]=fwd_sel[1]=3 with issue_accept=1.
- Youngest-wins: addu $4 then lw $4 then a reader of $4 → stall on the load entry (index 0). A reader of $0 after writes to $0 → sel=0, no stall.
- HI/LO: mtlo then mflo → LO port sel=1. div (DIV_LAT=32) then mfhi → stall_req for 32 cycles, then sel=0 and hilo_busy=0.
- Hold/flush: pipe_hold for 3 cycles in the middle of a load-use stall → entries unchanged and the stall ends 3 cycles later. flush with a dependent instruction in ID → stall_req=0 and a bubble enters EX.
- Reset: reset asserted with count=17 and all entries valid → the next cycle shows hilo_busy=0, all fwd_sel=0, stall_req=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: registered scoreboard of in-flight GPR/HI/LO writes for
// the stages after ID. Produces per-read-port forwarding selects, load-use and
// HI/LO-busy stalls, and the multi-cycle divider countdown.
module hazard_scoreboard #(
  parameter int NUM_RD     = 4,
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 2,
  parameter int DIV_LAT    = 32,
  parameter int SEL_W      = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pipe_hold,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_regwrite,
  input  logic [4:0]                issue_waddr,
  input  logic                      issue_memread,
  input  logic                      issue_wlo,
  input  logic                      issue_whi,
  input  logic                      issue_div,
  input  logic [NUM_RD-1:0]         rd_en,
  input  logic [2*NUM_RD-1:0]       rd_kind,
  input  logic [5*NUM_RD-1:0]       rd_addr,
  output logic [SEL_W*NUM_RD-1:0]   fwd_sel,
  output logic                      stall_req,
  output logic                      issue_accept,
  output logic                      hilo_busy
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  // Scoreboard entries; index 0 = EX (youngest), STAGES-1 = WB (oldest).
  // gw marks a GPR write to a nonzero register, so $0 never matches.
  logic [STAGES-1:0] v_q,  v_d;
  logic [STAGES-1:0] gw_q, gw_d;
  logic [STAGES-1:0] ld_q, ld_d;
  logic [STAGES-1:0] lo_q, lo_d;
  logic [STAGES-1:0] hi_q, hi_d;
  logic [4:0]        wa_q [STAGES];
  logic [4:0]        wa_d [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [SEL_W*NUM_RD-1:0] sel_s;
  logic                    load_hit_s;
  logic                    hilo_rd_s;
  logic                    found_s;
  logic                    hit_s;
  logic [1:0]              kind_s;
  logic [4:0]              addr_s;
  logic                    live_s;
  logic                    busy_s;
  logic                    stall_s;
  logic                    accept_s;

  // Per-port youngest-match search and load-use detection.
  always_comb begin
    sel_s      = '0;
    load_hit_s = 1'b0;
    hilo_rd_s  = 1'b0;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    kind_s     = 2'b00;
    addr_s     = 5'd0;
    for (int p = 0; p < NUM_RD; p++) begin
      kind_s  = rd_kind[2*p +: 2];
      addr_s  = rd_addr[5*p +: 5];
      found_s = 1'b0;
      if (rd_en[p] && (kind_s != 2'b11)) begin
        if (kind_s != 2'b00) begin
          hilo_rd_s = 1'b1;
        end else begin
          hilo_rd_s = hilo_rd_s;
        end
        for (int i = 0; i < STAGES; i++) begin
          case (kind_s)
            2'b00:   hit_s = v_q[i] && gw_q[i] && (wa_q[i] == addr_s) && (addr_s != 5'd0);
            2'b01:   hit_s = v_q[i] && lo_q[i];
            2'b10:   hit_s = v_q[i] && hi_q[i];
            default: hit_s = 1'b0;
          endcase
          if (hit_s && !found_s) begin
            found_s                  = 1'b1;
            sel_s[SEL_W*p +: SEL_W]  = SEL_W'(i + 1);
            if (ld_q[i] && (i < LOAD_READY)) begin
              load_hit_s = 1'b1;
            end else begin
              load_hit_s = load_hit_s;
            end
          end else begin
            found_s = found_s;
          end
        end
      end else begin
        found_s = 1'b0;
      end
    end
  end

  // Stall and accept decisions; a flushed or invalid instruction never stalls.
  always_comb begin
    live_s   = issue_valid && !flush;
    busy_s   = (cnt_q != '0);
    stall_s  = live_s && (load_hit_s ||
               (busy_s && (hilo_rd_s || issue_wlo || issue_whi || issue_div)));
    accept_s = live_s && !stall_s && !pipe_hold && !reset;
  end

  // Next-state for the entry shift chain and the divider countdown.
  always_comb begin
    v_d   = v_q;
    gw_d  = gw_q;
    ld_d  = ld_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    cnt_d = cnt_q;
    for (int i = 0; i < STAGES; i++) begin
      wa_d[i] = wa_q[i];
    end
    if (!pipe_hold) begin
      for (int i = STAGES - 1; i >= 1; i--) begin
        v_d[i]  = v_q[i-1];
        gw_d[i] = gw_q[i-1];
        ld_d[i] = ld_q[i-1];
        lo_d[i] = lo_q[i-1];
        hi_d[i] = hi_q[i-1];
        wa_d[i] = wa_q[i-1];
      end
      gw_d[0] = accept_s && issue_regwrite && (issue_waddr != 5'd0);
      lo_d[0] = accept_s && issue_wlo;
      hi_d[0] = accept_s && issue_whi;
      v_d[0]  = gw_d[0] || lo_d[0] || hi_d[0];
      ld_d[0] = accept_s && issue_memread;
      wa_d[0] = accept_s ? issue_waddr : 5'd0;
      if (accept_s && issue_div) begin
        cnt_d = CNT_W'(DIV_LAT);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State register with synchronous reset clearing entries and countdown.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_q   <= '0;
      gw_q  <= '0;
      ld_q  <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        wa_q[i] <= 5'd0;
      end
    end else begin
      v_q   <= v_d;
      gw_q  <= gw_d;
      ld_q  <= ld_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        wa_q[i] <= wa_d[i];
      end
    end
  end

  // Output drive; everything is forced quiet while reset is asserted.
  always_comb begin
    if (reset) begin
      fwd_sel      = '0;
      stall_req    = 1'b0;
      issue_accept = 1'b0;
      hilo_busy    = 1'b0;
    end else begin
      fwd_sel      = sel_s;
      stall_req    = stall_s;
      issue_accept = accept_s;
      hilo_busy    = busy_s;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios followed by random traffic,
// all checked against a queue-based model of the in-flight instructions.
module tb_hazard_scoreboard;

  logic        clock;
  logic        reset;
  logic        pipe_hold;
  logic        flush;
  logic        issue_valid;
  logic        issue_regwrite;
  logic [4:0]  issue_waddr;
  logic        issue_memread;
  logic        issue_wlo;
  logic        issue_whi;
  logic        issue_div;
  logic [3:0]  rd_en;
  logic [7:0]  rd_kind;
  logic [19:0] rd_addr;
  logic [7:0]  fwd_sel;
  logic        stall_req;
  logic        issue_accept;
  logic        hilo_busy;

  hazard_scoreboard dut (
    .clock          (clock),
    .reset          (reset),
    .pipe_hold      (pipe_hold),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_waddr    (issue_waddr),
    .issue_memread  (issue_memread),
    .issue_wlo      (issue_wlo),
    .issue_whi      (issue_whi),
    .issue_div      (issue_div),
    .rd_en          (rd_en),
    .rd_kind        (rd_kind),
    .rd_addr        (rd_addr),
    .fwd_sel        (fwd_sel),
    .stall_req      (stall_req),
    .issue_accept   (issue_accept),
    .hilo_busy      (hilo_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit       gw;
    bit [4:0] wa;
    bit       ld;
    bit       lo;
    bit       hi;
  } ins_t;

  ins_t q[$];        // q[0] = most recently issued instruction (EX)
  int   div_left;
  int   total;
  int   bad;
  logic m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    ins_t z;
    z = '{gw: 1'b0, wa: 5'd0, ld: 1'b0, lo: 1'b0, hi: 1'b0};
    q.delete();
    for (int k = 0; k < 3; k++) q.push_back(z);
    div_left = 0;
  endtask

  task automatic model_eval(output logic [7:0] e_sel, output logic e_stall,
                            output logic e_acc, output logic e_busy);
    bit ld_st, hl_rd, found, hit;
    bit [1:0] k;
    bit [4:0] a;
    e_sel = 8'd0;
    ld_st = 1'b0;
    hl_rd = 1'b0;
    for (int p = 0; p < 4; p++) begin
      k = rd_kind[2*p +: 2];
      a = rd_addr[5*p +: 5];
      found = 1'b0;
      if (rd_en[p] && k != 2'd3) begin
        if (k != 2'd0) hl_rd = 1'b1;
        for (int j = 0; j < 3; j++) begin
          if (k == 2'd0)      hit = q[j].gw && q[j].wa == a && a != 5'd0;
          else if (k == 2'd1) hit = q[j].lo;
          else                hit = q[j].hi;
          if (hit && !found) begin
            found = 1'b1;
            e_sel[2*p +: 2] = 2'(j + 1);
            if (q[j].ld && j < 2) ld_st = 1'b1;
          end
        end
      end
    end
    e_busy  = div_left != 0;
    e_stall = issue_valid && !flush &&
              (ld_st || (e_busy && (hl_rd || issue_wlo || issue_whi || issue_div)));
    e_acc   = issue_valid && !e_stall && !flush && !pipe_hold;
    if (reset) begin
      e_sel = 8'd0; e_stall = 1'b0; e_acc = 1'b0; e_busy = 1'b0;
    end
  endtask

  // Check DUT outputs against the model at the falling edge.
  task automatic probe(input string tag);
    logic [7:0] es;
    logic est, eac, ebz;
    @(negedge clock);
    model_eval(es, est, eac, ebz);
    m_acc = eac;
    chk({tag, ".sel"},   32'(fwd_sel),      32'(es));
    chk({tag, ".stall"}, 32'(stall_req),    32'(est));
    chk({tag, ".acc"},   32'(issue_accept), 32'(eac));
    chk({tag, ".busy"},  32'(hilo_busy),    32'(ebz));
  endtask

  // Advance one clock and update the model the way the pipeline moves.
  task automatic tick();
    ins_t n;
    @(posedge clock);
    if (reset) begin
      model_clear();
    end else if (!pipe_hold) begin
      n.gw = m_acc && issue_regwrite && issue_waddr != 5'd0;
      n.wa = issue_waddr;
      n.ld = m_acc && issue_memread;
      n.lo = m_acc && issue_wlo;
      n.hi = m_acc && issue_whi;
      q.push_front(n);
      void'(q.pop_back());
      if (m_acc && issue_div) div_left = 32;
      else if (div_left > 0) div_left--;
    end
    #1;
  endtask

  task automatic idle();
    pipe_hold = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_regwrite = 1'b0;
    issue_waddr = 5'd0; issue_memread = 1'b0; issue_wlo = 1'b0; issue_whi = 1'b0;
    issue_div = 1'b0; rd_en = 4'd0; rd_kind = 8'd0; rd_addr = 20'd0;
  endtask

  task automatic instr(input bit rw, input bit [4:0] wa, input bit ld,
                       input bit lo, input bit hi, input bit dv);
    idle();
    issue_valid = 1'b1; issue_regwrite = rw; issue_waddr = wa;
    issue_memread = ld; issue_wlo = lo; issue_whi = hi; issue_div = dv;
  endtask

  task automatic rd(input int p, input bit [1:0] k, input bit [4:0] a);
    rd_en[p] = 1'b1;
    rd_kind[2*p +: 2] = k;
    rd_addr[5*p +: 5] = a;
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_acc = 1'b0;
    model_clear();
    idle();
    reset = 1'b1;
    #1;
    probe("rst0"); tick();
    probe("rst1"); tick();
    reset = 1'b0;

    // ALU chain on $3
    instr(1, 5'd3, 0, 0, 0, 0); probe("alu_w"); tick();
    for (int d = 1; d <= 4; d++) begin
      instr(0, 5'd0, 0, 0, 0, 0); rd(0, 2'd0, 5'd3);
      probe("alu_r");
      chk("alu_chain_sel", 32'(fwd_sel[1:0]), (d == 4) ? 32'd0 : 32'(d));
      chk("alu_chain_nostall", 32'(stall_req), 32'd0);
      tick();
    end

    // Load-use: lw $5 then addu $6,$5,$5
    instr(1, 5'd5, 1, 0, 0, 0); probe("lw5"); tick();
    instr(1, 5'd6, 0, 0, 0, 0); rd(0, 2'd0, 5'd5); rd(1, 2'd0, 5'd5);
    for (int c = 0; c < 2; c++) begin
      probe("lu_wait"); chk("lu_stall", 32'(stall_req), 32'd1); tick();
    end
    probe("lu_go");
    chk("lu_sel", 32'(fwd_sel[3:0]), 32'hF);
    chk("lu_acc", 32'(issue_accept), 32'd1);
    tick();

    // Youngest wins: addu $4, lw $4, reader of $4
    instr(1, 5'd4, 0, 0, 0, 0); probe("yw_a"); tick();
    instr(1, 5'd4, 1, 0, 0, 0); probe("yw_l"); tick();
    instr(0, 5'd0, 0, 0, 0, 0); rd(2, 2'd0, 5'd4);
    probe("yw_r");
    chk("yw_stall", 32'(stall_req), 32'd1);
    chk("yw_sel", 32'(fwd_sel[5:4]), 32'd1);
    tick(); probe("yw_r2"); tick(); probe("yw_r3"); tick();
    instr(1, 5'd0, 0, 0, 0, 0); probe("z0a"); tick();
    instr(1, 5'd0, 1, 0, 0, 0); probe("z0b"); tick();
    instr(0, 5'd0, 0, 0, 0, 0); rd(3, 2'd0, 5'd0);
    probe("z0r");
    chk("zero_sel", 32'(fwd_sel), 32'd0);
    chk("zero_nostall", 32'(stall_req), 32'd0);
    tick();

    // HI/LO: mtlo then mflo; div then mfhi
    instr(0, 5'd0, 0, 1, 0, 0); probe("mtlo"); tick();
    instr(1, 5'd7, 0, 0, 0, 0); rd(0, 2'd1, 5'd0);
    probe("mflo"); chk("lo_sel", 32'(fwd_sel[1:0]), 32'd1); tick();
    instr(0, 5'd0, 0, 0, 0, 1); probe("div"); tick();
    instr(1, 5'd8, 0, 0, 0, 0); rd(0, 2'd2, 5'd0);
    for (int c = 0; c < 32; c++) begin
      probe("mfhi_wait"); chk("div_stall", 32'(stall_req), 32'd1); tick();
    end
    probe("mfhi_go");
    chk("div_done_stall", 32'(stall_req), 32'd0);
    chk("div_done_busy", 32'(hilo_busy), 32'd0);
    chk("div_done_sel", 32'(fwd_sel[1:0]), 32'd0);
    tick();

    // Hold in the middle of a load-use stall
    instr(1, 5'd9, 1, 0, 0, 0); probe("lw9"); tick();
    instr(0, 5'd0, 0, 0, 0, 0); rd(0, 2'd0, 5'd9);
    probe("h0"); chk("hold_pre_stall", 32'(stall_req), 32'd1); tick();
    pipe_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      probe("h_frz");
      chk("hold_stall", 32'(stall_req), 32'd1);
      chk("hold_entry", 32'(fwd_sel[1:0]), 32'd2);
      tick();
    end
    pipe_hold = 1'b0;
    probe("h_rel"); chk("hold_rel_stall", 32'(stall_req), 32'd1); tick();
    probe("h_end");
    chk("hold_end_stall", 32'(stall_req), 32'd0);
    chk("hold_end_sel", 32'(fwd_sel[1:0]), 32'd3);
    tick();

    // Flush with a dependent instruction in ID
    instr(1, 5'd10, 1, 0, 0, 0); probe("lw10"); tick();
    instr(0, 5'd0, 0, 0, 0, 0); rd(0, 2'd0, 5'd10); flush = 1'b1;
    probe("fl");
    chk("flush_nostall", 32'(stall_req), 32'd0);
    chk("flush_noacc", 32'(issue_accept), 32'd0);
    tick();
    flush = 1'b0;
    probe("fl_after");
    chk("flush_bubble_sel", 32'(fwd_sel[1:0]), 32'd2);
    tick();

    // Reset mid-divide with a full scoreboard
    instr(0, 5'd0, 0, 0, 0, 1); probe("div2"); tick();
    for (int c = 0; c < 15; c++) begin
      instr(1, 5'(11 + (c % 3)), 0, 0, 0, 0); probe("fill"); tick();
    end
    instr(0, 5'd0, 0, 0, 0, 0); rd(0, 2'd0, 5'd13); rd(1, 2'd0, 5'd12); rd(2, 2'd2, 5'd0);
    chk("pre_rst_count", 32'(div_left), 32'd17);
    reset = 1'b1;
    probe("rst_mid"); tick();
    reset = 1'b0;
    probe("rst_post");
    chk("rst_busy", 32'(hilo_busy), 32'd0);
    chk("rst_sel", 32'(fwd_sel), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      reset          = ($urandom % 100) == 0;
      pipe_hold      = ($urandom % 8) == 0;
      flush          = ($urandom % 8) == 0;
      issue_valid    = ($urandom % 4) != 0;
      issue_regwrite = ($urandom % 3) != 0;
      issue_waddr    = 5'($urandom % 4);
      issue_memread  = ($urandom % 4) == 0;
      issue_wlo      = ($urandom % 8) == 0;
      issue_whi      = ($urandom % 8) == 0;
      issue_div      = ($urandom % 40) == 0;
      rd_en          = 4'($urandom);
      rd_kind        = 8'($urandom);
      for (int p = 0; p < 4; p++) rd_addr[5*p +: 5] = 5'($urandom % 4);
      probe("rand");
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
